// File: rtl/signed_addsub_sat_pipe.sv
// Two-stage pipelined signed adder/subtractor with overflow flag, optional
// saturation and a saturating count of overflowed results.
module signed_addsub_sat_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    input  logic             ovf_cnt_clr,
    output logic             res_vld,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_vld_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sub_reg;
    logic             sat_reg;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             ovf_next;
    logic [WIDTH-1:0] res_next;
    logic             ovf_event;

    logic             res_vld_reg;
    logic [WIDTH-1:0] res_reg;
    logic             overflow_reg;
    logic [CNT_W-1:0] ovf_cnt_reg;
    logic [CNT_W-1:0] ovf_cnt_next;

    // Stage 1: capture operands and per-operation mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sub_reg    <= 1'b0;
            sat_reg    <= 1'b0;
        end else begin
            s1_vld_reg <= arg_vld;
            if (arg_vld) begin
                a_reg   <= a;
                b_reg   <= b;
                sub_reg <= sub;
                sat_reg <= sat;
            end
        end
    end

    // Subtraction is A + ~B + 1; the +1 enters as the carry-in term below
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_eff
            assign b_eff[gi] = b_reg[gi] ^ sub_reg;
        end
    endgenerate

    assign sum_ext   = {a_reg[WIDTH-1], a_reg} + {b_eff[WIDTH-1], b_eff}
                     + {{WIDTH{1'b0}}, sub_reg};
    assign ovf_next  = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    assign ovf_event = s1_vld_reg & ovf_next;

    // Extended MSB carries the true sign of the result, choosing the clamp rail
    always_comb begin
        res_next = sum_ext[WIDTH-1:0];
        if (ovf_next && sat_reg) begin
            res_next = sum_ext[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

    // A clear coinciding with an event restarts at 1 so that event is kept
    always_comb begin
        ovf_cnt_next = ovf_cnt_reg;
        if (ovf_cnt_clr) begin
            ovf_cnt_next = ovf_event ? CNT_W'(1) : '0;
        end else if (ovf_event && (ovf_cnt_reg != {CNT_W{1'b1}})) begin
            ovf_cnt_next = ovf_cnt_reg + CNT_W'(1);
        end
    end

    // Stage 2: result registers hold their value across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld_reg  <= 1'b0;
            res_reg      <= '0;
            overflow_reg <= 1'b0;
            ovf_cnt_reg  <= '0;
        end else begin
            res_vld_reg <= s1_vld_reg;
            ovf_cnt_reg <= ovf_cnt_next;
            if (s1_vld_reg) begin
                res_reg      <= res_next;
                overflow_reg <= ovf_next;
            end
        end
    end

    assign res_vld  = res_vld_reg;
    assign res      = res_reg;
    assign overflow = overflow_reg;
    assign ovf_cnt  = ovf_cnt_reg;

endmodule
